ip_z80_busctrl: RTL and testbench

//  Parametrised Z80 bus controller: CPU clock-enable divider, memory page/IO window

---
 rtl/ip_bus_pkg.sv | 17 +
 rtl/ip_clken_div.sv | 36 +++
 rtl/ip_z80_busctrl.sv | 175 +++++++++++++++++
 tb/tb_ip_z80_busctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ip_bus_pkg.sv
// Shared definitions for CPU bus controllers: WAIT FSM states, idle read value,
// and the width helper for a flat slave index (memory pages first, then I/O windows).
package ip_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } bus_state_e;

    localparam logic [7:0] RDATA_IDLE = 8'hFF;

    function automatic int unsigned slave_idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ip_clken_div.sv
// CPU clock-enable divider: one single-cycle pulse every CPU_DIV clocks,
// restarted from zero while cpu_hold is high.
module ip_clken_div #(
    parameter int unsigned CPU_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic cpu_hold,
    output logic cpu_enable
);

    localparam int unsigned CW = (CPU_DIV <= 1) ? 1 : $clog2(CPU_DIV);
    localparam logic [CW-1:0] LAST = CW'(CPU_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (cpu_hold || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Gated by reset too, so CPU_DIV=1 does not pulse while in reset.
    assign cpu_enable = !reset && !cpu_hold && (cnt_q == LAST);

endmodule

// File: rtl/ip_z80_busctrl.sv
// Z80 bus controller: clock-enable divider, page / I/O window chip selects,
// registered read-data capture, and WAIT insertion for slow slaves with timeout.
module ip_z80_busctrl
    import ip_bus_pkg::*;
#(
    parameter int unsigned CPU_DIV      = 2,
    parameter int unsigned PAGE_BITS    = 2,
    parameter int unsigned NUM_IO       = 4,
    parameter logic [7:0]  IO_BASE      = 8'h10,
    parameter int unsigned IO_SIZE_LOG2 = 2,
    parameter logic [(1 << PAGE_BITS) + NUM_IO - 1:0] SLOW_MASK = '0,
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cpu_hold,
    output logic                           cpu_enable,
    input  logic [15:0]                    a,
    input  logic                           mreq_n,
    input  logic                           iorq_n,
    input  logic                           m1_n,
    input  logic                           rd_n,
    input  logic                           wr_n,
    output logic                           wait_n,
    output logic [7:0]                     cpu_rdata,
    output logic [(1 << PAGE_BITS)-1:0]    mem_cs_n,
    output logic [NUM_IO-1:0]              io_cs_n,
    input  logic [8*(1 << PAGE_BITS)-1:0]  mem_rdata,
    input  logic [(1 << PAGE_BITS)-1:0]    mem_rdata_en,
    input  logic [8*NUM_IO-1:0]            io_rdata,
    input  logic [NUM_IO-1:0]              io_rdata_en,
    output logic                           timeout_err,
    output logic [1:0]                     dbg_state
);

    localparam int unsigned NUM_PAGES = 1 << PAGE_BITS;
    localparam int unsigned NUM_SLV   = NUM_PAGES + NUM_IO;
    localparam int unsigned SW        = slave_idx_w(NUM_SLV);
    localparam int          IO_SIZE   = 1 << IO_SIZE_LOG2;
    localparam logic [7:0]  TMO_LAST  = 8'(WAIT_TIMEOUT - 1);

    ip_clken_div #(.CPU_DIV(CPU_DIV)) u_div (
        .clk        (clk),
        .reset      (reset),
        .cpu_hold   (cpu_hold),
        .cpu_enable (cpu_enable)
    );

    logic [PAGE_BITS-1:0] page;
    logic [NUM_IO-1:0]    io_hit;
    assign page = a[15 -: PAGE_BITS];

    for (genvar p = 0; p < NUM_PAGES; p++) begin : g_page
        assign mem_cs_n[p] = (page == PAGE_BITS'(p)) ? mreq_n : 1'b1;
    end

    // Window bounds are compared in 32-bit space so ports past 8'hFF never alias.
    for (genvar i = 0; i < NUM_IO; i++) begin : g_io
        localparam int LO = int'(IO_BASE) + i * IO_SIZE;
        localparam int HI = LO + IO_SIZE;
        assign io_hit[i]  = (int'(a[7:0]) >= LO) && (int'(a[7:0]) < HI);
        assign io_cs_n[i] = !(io_hit[i] && !iorq_n && m1_n);
    end

    logic [NUM_SLV-1:0]   all_en;
    logic [8*NUM_SLV-1:0] all_data;
    assign all_en   = {io_rdata_en, mem_rdata_en};
    assign all_data = {io_rdata, mem_rdata};

    logic          sel_valid;
    logic [SW-1:0] sel_idx;
    logic          sel_slow;
    logic          sel_en;

    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        if (!mreq_n) begin
            sel_valid = 1'b1;
            sel_idx   = SW'(page);
        end else if (!iorq_n && m1_n) begin
            for (int i = NUM_IO - 1; i >= 0; i--) begin
                if (io_hit[i]) begin
                    sel_valid = 1'b1;
                    sel_idx   = SW'(NUM_PAGES + i);
                end
            end
        end
    end

    assign sel_slow = sel_valid && SLOW_MASK[sel_idx];
    assign sel_en   = sel_valid && all_en[sel_idx];

    // Lowest-index valid wins; later ones overwrite going downward.
    logic       cap_hit;
    logic [7:0] cap_data;

    always_comb begin
        cap_hit  = 1'b0;
        cap_data = RDATA_IDLE;
        for (int s = NUM_SLV - 1; s >= 0; s--) begin
            if (all_en[s]) begin
                cap_hit  = 1'b1;
                cap_data = all_data[8*s +: 8];
            end
        end
    end

    bus_state_e state_q;
    logic       wait_n_q;
    logic [7:0] tmo_cnt_q;
    logic       timeout_err_q;
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wait_n_q      <= 1'b1;
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
            rdata_q       <= RDATA_IDLE;
        end else begin
            if (cap_hit) begin
                rdata_q <= cap_data;
            end else if (rd_n) begin
                rdata_q <= RDATA_IDLE;
            end
            case (state_q)
                ST_IDLE: begin
                    // Data already present on the first cycle needs no wait state.
                    if (!rd_n && sel_slow) begin
                        if (sel_en) begin
                            state_q <= ST_DONE;
                        end else begin
                            state_q   <= ST_WAIT;
                            wait_n_q  <= 1'b0;
                            tmo_cnt_q <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    if (rd_n) begin
                        state_q  <= ST_IDLE;
                        wait_n_q <= 1'b1;
                    end else if (sel_en) begin
                        state_q  <= ST_DONE;
                        wait_n_q <= 1'b1;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        state_q       <= ST_DONE;
                        wait_n_q      <= 1'b1;
                        timeout_err_q <= 1'b1;
                        rdata_q       <= RDATA_IDLE;
                    end
                end
                ST_DONE: begin
                    if (rd_n) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign wait_n      = wait_n_q;
    assign cpu_rdata   = rdata_q;
    assign timeout_err = timeout_err_q;
    assign dbg_state   = state_q;

    // Writes never wait, and only part of the address feeds the decode.
    logic unused_bits;
    assign unused_bits = ^{a, wr_n};

endmodule

// File: tb/tb_ip_z80_busctrl.sv
// Bench for ip_z80_busctrl: bus-level reference model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_ip_z80_busctrl;

    localparam int         DIV  = 2;
    localparam int         NP   = 4;
    localparam int         NIO  = 4;
    localparam int         TO   = 16;
    localparam logic [7:0] SLOW = 8'h08;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_hold = 1'b0;
    logic        cpu_enable;
    logic [15:0] a = '0;
    logic        mreq_n = 1'b1, iorq_n = 1'b1, m1_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
    logic        wait_n;
    logic [7:0]  cpu_rdata;
    logic [3:0]  mem_cs_n;
    logic [3:0]  io_cs_n;
    logic [31:0] mem_rdata = '0;
    logic [3:0]  mem_rdata_en = '0;
    logic [31:0] io_rdata = '0;
    logic [3:0]  io_rdata_en = '0;
    logic        timeout_err;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    ip_z80_busctrl #(
        .CPU_DIV(DIV), .PAGE_BITS(2), .NUM_IO(NIO), .IO_BASE(8'h10),
        .IO_SIZE_LOG2(2), .SLOW_MASK(SLOW), .WAIT_TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .cpu_hold(cpu_hold), .cpu_enable(cpu_enable),
        .a(a), .mreq_n(mreq_n), .iorq_n(iorq_n), .m1_n(m1_n), .rd_n(rd_n), .wr_n(wr_n),
        .wait_n(wait_n), .cpu_rdata(cpu_rdata), .mem_cs_n(mem_cs_n), .io_cs_n(io_cs_n),
        .mem_rdata(mem_rdata), .mem_rdata_en(mem_rdata_en), .io_rdata(io_rdata),
        .io_rdata_en(io_rdata_en), .timeout_err(timeout_err), .dbg_state(dbg_state)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: slave numbering is pages 0..3 then I/O windows 4..7.
    function automatic int sel_slave();
        int off;
        if (!mreq_n) return int'(a[15:14]);
        if (!iorq_n && m1_n) begin
            off = int'(a[7:0]) - 16;
            if (off >= 0 && off < 16) return NP + off / 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_mem_cs();
        logic [3:0] r;
        r = 4'hF;
        r[a[15:14]] = mreq_n;
        return r;
    endfunction

    function automatic logic [3:0] exp_io_cs();
        logic [3:0] r;
        int off;
        r = 4'hF;
        off = int'(a[7:0]) - 16;
        if (!iorq_n && m1_n && off >= 0 && off < 16) r[off / 4] = 1'b0;
        return r;
    endfunction

    int         run = 0;
    int         wlen = 0;
    logic [7:0] m_rdata = 8'hFF;
    logic       m_waiting = 1'b0;
    logic       m_done = 1'b0;
    logic       m_err = 1'b0;

    always @(posedge clk) begin
        int s;
        int w;
        logic [7:0]  en_all;
        logic [63:0] data_all;
        en_all   = {io_rdata_en, mem_rdata_en};
        data_all = {io_rdata, mem_rdata};
        if (reset) begin
            run = 0; m_rdata = 8'hFF; m_waiting = 1'b0; m_done = 1'b0; m_err = 1'b0;
        end else begin
            run = cpu_hold ? 0 : run + 1;
            s = sel_slave();
            w = -1;
            for (int i = 0; i < 8; i++) if (w < 0 && en_all[i]) w = i;
            if (w >= 0) m_rdata = data_all[w*8 +: 8];
            else if (rd_n) m_rdata = 8'hFF;
            if (m_waiting) begin
                wlen++;
                if (rd_n) m_waiting = 1'b0;
                else if (s >= 0 && en_all[s]) begin m_waiting = 1'b0; m_done = 1'b1; end
                else if (wlen == TO) begin
                    m_waiting = 1'b0; m_done = 1'b1; m_err = 1'b1; m_rdata = 8'hFF;
                end
            end else if (m_done) begin
                if (rd_n) m_done = 1'b0;
            end else if (!rd_n && s >= 0 && SLOW[s]) begin
                if (en_all[s]) m_done = 1'b1;
                else begin m_waiting = 1'b1; wlen = 0; end
            end
        end
    end

    int low_cnt = 0;

    always @(negedge clk) begin
        if (!wait_n) low_cnt++;
        check("m_cpu_enable", 32'(cpu_enable),
              32'(!reset && !cpu_hold && (run % DIV == DIV - 1)));
        check("m_wait_n", 32'(wait_n), 32'(!m_waiting));
        check("m_cpu_rdata", 32'(cpu_rdata), 32'(m_rdata));
        check("m_timeout_err", 32'(timeout_err), 32'(m_err));
        check("m_mem_cs_n", 32'(mem_cs_n), 32'(exp_mem_cs()));
        check("m_io_cs_n", 32'(io_cs_n), 32'(exp_io_cs()));
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic idle_bus();
        mreq_n = 1'b1; iorq_n = 1'b1; m1_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        mem_rdata_en = '0; io_rdata_en = '0;
    endtask

    task automatic io_decode(input logic [7:0] port, input logic m1, input logic [3:0] exp);
        a = {8'h00, port}; mreq_n = 1'b1; iorq_n = 1'b0; m1_n = m1;
        #1 check("io_decode", 32'(io_cs_n), 32'(exp));
    endtask

    initial begin
        int pulses;
        idle_bus();
        tick(3);
        check("rst_rdata", 32'(cpu_rdata), 32'h0FF);
        check("rst_wait_n", 32'(wait_n), 32'd1);
        check("rst_err", 32'(timeout_err), 32'd0);
        check("rst_enable", 32'(cpu_enable), 32'd0);
        reset = 1'b0;

        pulses = 0;
        for (int i = 0; i < 10; i++) begin tick(1); if (cpu_enable) pulses++; end
        check("div_pulses", 32'(pulses), 32'd5);
        cpu_hold = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin tick(1); if (cpu_enable) pulses++; end
        check("hold_pulses", 32'(pulses), 32'd0);
        cpu_hold = 1'b0;

        a = 16'hC012; mreq_n = 1'b0;
        #1 check("mem_decode_p3", 32'(mem_cs_n), 32'h7);
        a = 16'h0000;
        #1 check("mem_decode_p0", 32'(mem_cs_n), 32'hE);
        io_decode(8'h15, 1'b1, 4'b1101);
        io_decode(8'h15, 1'b0, 4'hF);
        io_decode(8'h0F, 1'b1, 4'hF);
        io_decode(8'h10, 1'b1, 4'b1110);
        io_decode(8'h1F, 1'b1, 4'b0111);
        io_decode(8'h20, 1'b1, 4'hF);
        idle_bus();
        tick(2);

        a = 16'h0000; mreq_n = 1'b0; rd_n = 1'b0;
        mem_rdata[7:0] = 8'h3C; io_rdata[7:0] = 8'hA5;
        mem_rdata_en[0] = 1'b1; io_rdata_en[0] = 1'b1;
        tick(1);
        check("mux_prio", 32'(cpu_rdata), 32'h3C);
        mem_rdata_en = '0; io_rdata_en = '0;
        tick(1);
        check("mux_hold", 32'(cpu_rdata), 32'h3C);
        idle_bus();
        tick(1);
        check("mux_idle", 32'(cpu_rdata), 32'hFF);

        a = 16'hC000; mreq_n = 1'b0; rd_n = 1'b0; low_cnt = 0;
        tick(5);
        mem_rdata[31:24] = 8'h42; mem_rdata_en[3] = 1'b1;
        tick(1);
        mem_rdata_en = '0;
        tick(1);
        check("slow_low_cycles", 32'(low_cnt), 32'd5);
        check("slow_rdata", 32'(cpu_rdata), 32'h42);
        check("slow_wait_n", 32'(wait_n), 32'd1);
        check("slow_err", 32'(timeout_err), 32'd0);
        idle_bus();
        tick(2);

        a = 16'hC000; mreq_n = 1'b0; wr_n = 1'b0; low_cnt = 0;
        tick(4);
        check("write_no_wait", 32'(low_cnt), 32'd0);
        idle_bus();
        tick(2);

        a = 16'hC000; mreq_n = 1'b0; rd_n = 1'b0; low_cnt = 0;
        tick(25);
        check("tmo_low_cycles", 32'(low_cnt), 32'd16);
        check("tmo_rdata", 32'(cpu_rdata), 32'hFF);
        check("tmo_err", 32'(timeout_err), 32'd1);
        check("tmo_wait_n", 32'(wait_n), 32'd1);
        idle_bus();
        tick(3);
        check("tmo_err_sticky", 32'(timeout_err), 32'd1);

        a = 16'hC000; mreq_n = 1'b0; rd_n = 1'b0;
        tick(4);
        check("rst_mid_wait_pre", 32'(wait_n), 32'd0);
        reset = 1'b1;
        tick(1);
        check("rst_mid_wait_n", 32'(wait_n), 32'd1);
        check("rst_mid_err", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        idle_bus();
        tick(3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
